// File: rtl/proc_hier_stats_pkg.sv
// Shared types and defaults for the commit-side
// statistics and trace unit.
package proc_hier_stats_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_num_t;

endpackage

// File: rtl/proc_hier_stats_sat_counter.sv
// Saturating event counter, sticks at all-ones.
// Async active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count qualified events until all-ones, then hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/proc_hier_stats.sv
// Retirement/cache statistics counters and a
// registered per-cycle trace record.
module proc_hier_stats
  import proc_hier_stats_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write,
  input  reg_num_t         write_reg,
  input  word_t            write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  word_t            mem_addr,
  input  word_t            mem_data_in,
  input  word_t            mem_data_out,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] icache_req_count,
  output logic [CNT_W-1:0] icache_hit_count,
  output logic [CNT_W-1:0] dcache_req_count,
  output logic [CNT_W-1:0] dcache_hit_count,
  output logic             halted,
  output logic             trc_reg_v,
  output reg_num_t         trc_reg_num,
  output word_t            trc_reg_data,
  output logic             trc_ld_v,
  output logic             trc_st_v,
  output word_t            trc_mem_addr,
  output word_t            trc_mem_data
);

  logic active;
  logic retire;
  logic ihit;
  logic dhit;

  assign active = !halted;
  assign retire = halt | reg_write | mem_write;
  assign ihit   = icache_req & icache_hit;
  assign dhit   = dcache_req & dcache_hit;

  sat_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk(clk), .rst(rst), .en(active),
    .inc(1'b1), .cnt(cycle_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_inst (
    .clk(clk), .rst(rst), .en(active),
    .inc(retire), .cnt(inst_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ireq (
    .clk(clk), .rst(rst), .en(active),
    .inc(icache_req), .cnt(icache_req_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ihit (
    .clk(clk), .rst(rst), .en(active),
    .inc(ihit), .cnt(icache_hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dreq (
    .clk(clk), .rst(rst), .en(active),
    .inc(dcache_req), .cnt(dcache_req_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dhit (
    .clk(clk), .rst(rst), .en(active),
    .inc(dhit), .cnt(dcache_hit_count)
  );

  // Sticky halt flag, set by the first retiring HALT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted <= 1'b0;
    end else if (active && halt) begin
      halted <= 1'b1;
    end
  end

  // Register-write trace record; data held when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trc_reg_v    <= 1'b0;
      trc_reg_num  <= '0;
      trc_reg_data <= '0;
    end else if (active) begin
      trc_reg_v <= reg_write;
      if (reg_write) begin
        trc_reg_num  <= write_reg;
        trc_reg_data <= write_data;
      end
    end else begin
      trc_reg_v <= 1'b0;
    end
  end

  // Memory trace record; a store outranks a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trc_ld_v     <= 1'b0;
      trc_st_v     <= 1'b0;
      trc_mem_addr <= '0;
      trc_mem_data <= '0;
    end else if (active) begin
      trc_st_v <= mem_write;
      trc_ld_v <= mem_read & !mem_write;
      if (mem_write) begin
        trc_mem_addr <= mem_addr;
        trc_mem_data <= mem_data_in;
      end else if (mem_read) begin
        trc_mem_addr <= mem_addr;
        trc_mem_data <= mem_data_out;
      end
    end else begin
      trc_st_v <= 1'b0;
      trc_ld_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_hier_stats.sv
// Self-checking bench for proc_hier_stats:
// reference model plus directed checks.
module tb_proc_hier_stats;

  localparam longint MAXC = (64'd1 << 32) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_write = 1'b0;
  logic [2:0]  write_reg = '0;
  logic [15:0] write_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_data_in = '0;
  logic [15:0] mem_data_out = '0;
  logic        halt = 1'b0;
  logic        icache_req = 1'b0;
  logic        icache_hit = 1'b0;
  logic        dcache_req = 1'b0;
  logic        dcache_hit = 1'b0;

  logic [31:0] cycle_count, inst_count;
  logic [31:0] icache_req_count, icache_hit_count;
  logic [31:0] dcache_req_count, dcache_hit_count;
  logic        halted, trc_reg_v, trc_ld_v, trc_st_v;
  logic [2:0]  trc_reg_num;
  logic [15:0] trc_reg_data, trc_mem_addr, trc_mem_data;

  logic [3:0]  s_cyc, s_inst, s_ireq, s_ihit, s_dreq, s_dhit;
  logic        s_halted, s_reg_v, s_ld_v, s_st_v;
  logic [2:0]  s_reg_num;
  logic [15:0] s_reg_data, s_mem_addr, s_mem_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  proc_hier_stats dut (
    .clk(clk), .rst(rst),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .cycle_count(cycle_count), .inst_count(inst_count),
    .icache_req_count(icache_req_count),
    .icache_hit_count(icache_hit_count),
    .dcache_req_count(dcache_req_count),
    .dcache_hit_count(dcache_hit_count),
    .halted(halted), .trc_reg_v(trc_reg_v),
    .trc_reg_num(trc_reg_num), .trc_reg_data(trc_reg_data),
    .trc_ld_v(trc_ld_v), .trc_st_v(trc_st_v),
    .trc_mem_addr(trc_mem_addr), .trc_mem_data(trc_mem_data)
  );

  // Narrow instance that never halts: reaches saturation quickly.
  proc_hier_stats #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .halt(1'b0),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .cycle_count(s_cyc), .inst_count(s_inst),
    .icache_req_count(s_ireq), .icache_hit_count(s_ihit),
    .dcache_req_count(s_dreq), .dcache_hit_count(s_dhit),
    .halted(s_halted), .trc_reg_v(s_reg_v),
    .trc_reg_num(s_reg_num), .trc_reg_data(s_reg_data),
    .trc_ld_v(s_ld_v), .trc_st_v(s_st_v),
    .trc_mem_addr(s_mem_addr), .trc_mem_data(s_mem_data)
  );

  // Reference model state
  longint m_cyc, m_inst, m_ireq, m_ihit, m_dreq, m_dhit;
  bit     m_halted, m_reg_v, m_ld_v, m_st_v;
  int     m_reg_num, m_reg_data, m_addr, m_data;

  function automatic longint bump(longint v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cyc = 0; m_inst = 0; m_ireq = 0; m_ihit = 0;
    m_dreq = 0; m_dhit = 0;
    m_halted = 0; m_reg_v = 0; m_ld_v = 0; m_st_v = 0;
    m_reg_num = 0; m_reg_data = 0; m_addr = 0; m_data = 0;
  endtask

  // Model: apply the commit rules for each clock edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_clear();
    end else if (m_halted) begin
      m_reg_v = 0; m_ld_v = 0; m_st_v = 0;
    end else begin
      m_cyc = bump(m_cyc);
      if (halt || reg_write || mem_write) m_inst = bump(m_inst);
      if (icache_req) m_ireq = bump(m_ireq);
      if (icache_req && icache_hit) m_ihit = bump(m_ihit);
      if (dcache_req) m_dreq = bump(m_dreq);
      if (dcache_req && dcache_hit) m_dhit = bump(m_dhit);
      m_reg_v = reg_write;
      if (reg_write) begin
        m_reg_num = int'(write_reg);
        m_reg_data = int'(write_data);
      end
      m_st_v = mem_write;
      m_ld_v = mem_read && !mem_write;
      if (mem_write) begin
        m_addr = int'(mem_addr); m_data = int'(mem_data_in);
      end else if (mem_read) begin
        m_addr = int'(mem_addr); m_data = int'(mem_data_out);
      end
      if (halt) m_halted = 1;
    end
  end

  // Compare every output with the model on each falling edge.
  always @(negedge clk) begin
    chk("cycle_count", cycle_count, m_cyc);
    chk("inst_count", inst_count, m_inst);
    chk("icache_req_count", icache_req_count, m_ireq);
    chk("icache_hit_count", icache_hit_count, m_ihit);
    chk("dcache_req_count", dcache_req_count, m_dreq);
    chk("dcache_hit_count", dcache_hit_count, m_dhit);
    chk("halted", halted, m_halted);
    chk("trc_reg_v", trc_reg_v, m_reg_v);
    chk("trc_reg_num", trc_reg_num, m_reg_num);
    chk("trc_reg_data", trc_reg_data, m_reg_data);
    chk("trc_ld_v", trc_ld_v, m_ld_v);
    chk("trc_st_v", trc_st_v, m_st_v);
    chk("trc_mem_addr", trc_mem_addr, m_addr);
    chk("trc_mem_data", trc_mem_data, m_data);
  end

  task automatic idle_inputs();
    reg_write = 0; write_reg = '0; write_data = '0;
    mem_read = 0; mem_write = 0; mem_addr = '0;
    mem_data_in = '0; mem_data_out = '0; halt = 0;
    icache_req = 0; icache_hit = 0;
    dcache_req = 0; dcache_hit = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    idle_inputs();
    repeat (2) tick();
    chk("reset cycle_count", cycle_count, 0);
    chk("reset trc_reg_v", trc_reg_v, 0);
    rst = 1;

    repeat (10) tick();
    chk("idle cycle_count", cycle_count, 10);
    chk("idle inst_count", inst_count, 0);
    chk("idle small cycle", s_cyc, 10);

    reg_write = 1; write_reg = 3'd3; write_data = 16'h1234;
    tick(); idle_inputs();
    chk("rw valid", trc_reg_v, 1);
    chk("rw num", trc_reg_num, 3);
    chk("rw data", trc_reg_data, 16'h1234);
    chk("rw inst", inst_count, 1);

    mem_read = 1; mem_write = 1; mem_addr = 16'h0040;
    mem_data_in = 16'hBEEF; mem_data_out = 16'h1111;
    tick(); idle_inputs();
    chk("st valid", trc_st_v, 1);
    chk("st no ld", trc_ld_v, 0);
    chk("st data", trc_mem_data, 16'hBEEF);
    chk("st addr", trc_mem_addr, 16'h0040);
    chk("st inst", inst_count, 2);

    mem_read = 1; mem_addr = 16'h0080; mem_data_out = 16'h5555;
    tick(); idle_inputs();
    chk("ld valid", trc_ld_v, 1);
    chk("ld data", trc_mem_data, 16'h5555);
    chk("ld inst", inst_count, 2);
    tick();
    chk("ld drop", trc_ld_v, 0);
    chk("ld hold", trc_mem_data, 16'h5555);
    chk("rw hold", trc_reg_data, 16'h1234);

    icache_req = 1; icache_hit = 1;
    repeat (5) tick();
    icache_req = 0;
    repeat (3) tick();
    idle_inputs();
    chk("ireq count", icache_req_count, 5);
    chk("ihit count", icache_hit_count, 5);

    dcache_req = 1;
    repeat (2) tick();
    idle_inputs();
    chk("dreq miss", dcache_req_count, 2);
    chk("dhit miss", dcache_hit_count, 0);

    halt = 1; dcache_req = 1; dcache_hit = 1;
    reg_write = 1; write_reg = 3'd5; write_data = 16'hCAFE;
    tick(); idle_inputs();
    chk("halt flag", halted, 1);
    chk("halt inst", inst_count, 3);
    chk("halt dreq", dcache_req_count, 3);
    chk("halt rec", trc_reg_v, 1);
    chk("halt cycle", cycle_count, 25);
    chk("small sat", s_cyc, 15);

    reg_write = 1; write_reg = 3'd1; write_data = 16'h7777;
    mem_write = 1; mem_addr = 16'h0100; mem_data_in = 16'h9999;
    icache_req = 1; icache_hit = 1; dcache_req = 1; halt = 1;
    repeat (20) tick();
    idle_inputs();
    chk("frz cycle", cycle_count, 25);
    chk("frz inst", inst_count, 3);
    chk("frz dreq", dcache_req_count, 3);
    chk("frz ireq", icache_req_count, 5);
    chk("frz reg_v", trc_reg_v, 0);
    chk("frz st_v", trc_st_v, 0);
    chk("frz reg data", trc_reg_data, 16'hCAFE);
    chk("frz mem data", trc_mem_data, 16'h5555);
    chk("small ireq sat", s_ireq, 15);

    @(posedge clk); #2;
    rst = 0;
    #1;
    chk("arst cycle", cycle_count, 0);
    chk("arst inst", inst_count, 0);
    chk("arst halted", halted, 0);
    chk("arst reg data", trc_reg_data, 0);
    chk("arst mem addr", trc_mem_addr, 0);
    chk("arst small", s_cyc, 0);
    tick();
    rst = 1;
    repeat (3) tick();
    chk("restart cycle", cycle_count, 3);
    chk("restart halted", halted, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/proc_hier_stats.md
# proc_hier_stats

Commit-side statistics and trace unit of the processor hierarchy. It samples the pipeline's retirement signals (register write-back, data-memory access, halt) and the I/D cache request and hit strobes every cycle. It maintains cycle, instruction and cache counters, and emits one registered trace record per cycle for the simulation logger. It sits in the hierarchy top beside the processor core and the memory system, and is read by the performance bench.

## Interface
Parameters:
- CNT_W, 32, width of every counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- reg_write  in  1  write-back stage writes the register file this cycle
- write_reg  in  3  destination register number
- write_data  in  16  write-back data
- mem_read  in  1  data-memory load in memory stage
- mem_write  in  1  data-memory store in memory stage
- mem_addr  in  16  data-memory address
- mem_data_in  in  16  store data
- mem_data_out  in  16  load data
- halt  in  1  HALT instruction retiring
- icache_req, icache_hit, dcache_req, dcache_hit  in  1 each  cache request and hit strobes
- cycle_count, inst_count  out  CNT_W  cycle and retired-instruction counts
- icache_req_count, icache_hit_count, dcache_req_count, dcache_hit_count  out  CNT_W  cache event counts
- halted  out  1  sticky halt flag
- trc_reg_v, trc_reg_num[2:0], trc_reg_data[15:0]  out  registered register-write record
- trc_ld_v, trc_st_v, trc_mem_addr[15:0], trc_mem_data[15:0]  out  registered memory record

## Operation
- Active cycle: rst high and halted low.
- cycle_count: +1 every active cycle.
- inst_count: +1 in an active cycle when halt | reg_write | mem_write.
- Each *_req_count: +1 when its req is high.
- Each *_hit_count: +1 only when both hit and the matching req are high. A hit without a req is ignored.
- All counters saturate at all-ones. They do not wrap.
- halted: set in the first active cycle with halt high, and stays set until reset.
  - The halt cycle itself is still counted in every counter.
  - From the next cycle on, all counters and trace outputs freeze. Trace valids drop to 0.
- Register record:
  - trc_reg_v = reg_write.
  - trc_reg_num and trc_reg_data are captured from write_reg and write_data.
- Memory record:
  - mem_write has priority: trc_st_v = mem_write, and trc_mem_data = mem_data_in.
  - Otherwise trc_ld_v = mem_read, and trc_mem_data = mem_data_out.
  - trc_ld_v and trc_st_v are never both 1.
  - trc_mem_addr = mem_addr whenever either valid is set.
- Data fields are held at their last value when the matching valid is 0.

## Timing
- Reset: every counter, halted, all valids and all data fields are 0. Reset is applied asynchronously on rst falling.
- Release: the first rising edge with rst high is the first counted cycle, so cycle_count = 1 after it.
- Latency: all outputs are registered, one cycle after the sampled inputs.
- No combinational path from input to output.
- Reset asserted mid-run, including after halt: immediate clear. Counting restarts on release.
- Simultaneous halt and reg_write: counted once in inst_count, and the trace record is still emitted.

## Structure
- One module.
- A shared package holds:
  - CNT_W default
  - 16-bit word and 3-bit register-number typedefs
- Natural sub-module: sat_counter (CNT_W wide, inc and enable inputs, saturating, async active-low clear), instantiated 6 times.

## Test plan
- Reset, then 10 idle cycles → cycle_count = 10, all other counters 0, valids 0.
- reg_write=1, write_reg=3, write_data=0x1234 for 1 cycle → next cycle trc_reg_v=1, num=3, data=0x1234; inst_count=1.
- mem_read=1 with mem_write=1, addr=0x0040, mem_data_in=0xBEEF, mem_data_out=0x1111 → trc_st_v=1, trc_ld_v=0, trc_mem_data=0xBEEF; inst_count +1.
- icache_req=1 with icache_hit=1 for 5 cycles, then icache_hit=1 alone for 3 cycles → icache_req_count=5, icache_hit_count=5.
- halt=1 with dcache_req=1 for one cycle, then 20 cycles of activity → halted=1; inst_count and dcache_req_count include the halt cycle and stay frozen; cycle_count frozen.
- Preload a counter near all-ones via force, then increment → holds at all-ones. Assert rst low asynchronously mid-cycle → all outputs 0 immediately.
